display_share_ctrl: RTL and testbench
=====================================

# display_share_ctrl

Time-sharing controller for the four-digit seven-segment display. Arbitrates up to NUM_REQ requesters (e.g. counter, status code, error code) wanting the display, latches the winner's 16-bit value, and drives display_four_digits' `start_signal` and `input_value`. A minimum on-screen hold time prevents flicker between sources. Round-robin selection keeps any source from starving the others.

## Interface
- `NUM_REQ`, 3: number of requesters, 2..8.
- `VALUE_W`, 16: value width per requester (four hex nibbles).
- `HOLD_CYCLES`, 12_000_000: minimum display time per grant, in clk cycles (1 s at 12 MHz); ≥ 2.

- `clk`  in  1  system clock (12 MHz).
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  NUM_REQ  per-requester level request; bit i belongs to requester i.
- `req_value`  in  NUM_REQ*VALUE_W  packed values; requester i at bits [i*VALUE_W +: VALUE_W].
- `start_signal`  out  1  one-cycle pulse to display_four_digits; loads a new value.
- `input_value`  out  VALUE_W  registered value to display_four_digits.
- `grant`  out  NUM_REQ  one-hot current owner; zero when no owner.
- `busy`  out  1  high while a hold interval is running (SHOW or LOAD).

## Operation
- Reset values: state IDLE, `start_signal`=0, `input_value`=0, `grant`=0, `busy`=0, round-robin pointer=0, hold counter=0.
- Reset is asynchronous; asserting it mid-hold aborts immediately. No pulse is emitted on reset release.
- States: IDLE, LOAD, SHOW.
- IDLE: if `req`≠0, pick the winner by round-robin, searching from requester (last_owner+1) mod NUM_REQ upward. After reset the search starts at 0. Latch the winner's value into `input_value`, then go to LOAD. If `req`=0, stay in IDLE; `input_value` holds its last value, so the display keeps showing it.
- LOAD (exactly 1 cycle): `start_signal`=1, `grant`=one-hot winner, `busy`=1. Hold counter loads HOLD_CYCLES−1. Go to SHOW.
- SHOW: `busy`=1, `grant` held, counter decrements each cycle.
  - While `req[owner]`=1, `input_value` re-latches the owner's value every cycle (live update, no new pulse).
  - If the owner drops `req`, `input_value` freezes; the hold still runs to completion.
- End of hold (counter=0 in SHOW):
  - Any non-owner request pending: rotate to the round-robin winner among the others, latch its value, go to LOAD. The owner is excluded even if it still requests.
  - Only the owner requests: reload the counter with HOLD_CYCLES−1 and stay in SHOW. No pulse; `grant` unchanged.
  - No requests: `grant`=0, `busy`=0, go to IDLE. The pointer records the last owner.
- Requests arriving during SHOW are not queued separately. `req` is a level signal and is only sampled at decision points (IDLE each cycle, end of hold).
- Values of non-granted requesters are ignored.

## Timing
- `req` rising in cycle N while in IDLE:
  - `start_signal`=1 and `grant` valid in N+1.
  - `input_value` is the cycle-N value of the winner, visible from N+1, coincident with the pulse.
- A grant lasts exactly HOLD_CYCLES+1 cycles from LOAD to the next decision: 1 LOAD cycle plus HOLD_CYCLES SHOW cycles.
- Owner-to-owner handover: the old `grant` drops and the new `grant` rises in the same edge as the new `start_signal`. There is no gap cycle.
- Live update: a `req_value` change in cycle M appears on `input_value` in M+1.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Package `display_pkg`:
  - state typedef (IDLE/LOAD/SHOW);
  - default constants CLK_HZ=12_000_000 and HOLD_CYCLES;
  - digit-enable encodings shared with display_four_digits.
- Sub-module `rr_arbiter`: combinational. Inputs: `req`, pointer, exclude mask. Outputs: one-hot `pick` and `pick_valid`. Reusable for other shared resources.
- Hold counter width: $clog2(HOLD_CYCLES).

## Test plan
Common setup: NUM_REQ=3, HOLD_CYCLES=8, with display_four_digits instantiated downstream.
- Reset release, `req`=0 for 20 cycles → `start_signal` never pulses; `grant`=0, `busy`=0, `input_value`=0.
- `req`=001, value0=16'hABCD → one pulse 1 cycle later with `input_value`=ABCD, `grant`=001. `busy` high for 9 cycles, then low once `req` drops.
- `req`=111 held constantly → grants 001, 010, 100, 001 in order. Each gap between pulses is 9 cycles. `input_value` follows ABCD/1234/5678.
- Owner 0 alone holds `req`; value0 changes ABCD→1234 mid-hold → `input_value`=1234 one cycle later with no new pulse. At hold end the grant is renewed without a pulse.
- Owner 1 in SHOW and requester 0 raises `req` → the switch happens only at hold end: pulse plus `grant`=001. It never happens earlier.
- `reset` asserted during SHOW → outputs zero asynchronously. After release with `req`=110, the first grant is 010 (pointer restarts at 0).

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment display subsystem.
package display_pkg;

  localparam int unsigned CLK_HZ      = 12_000_000;
  localparam int unsigned HOLD_CYCLES = CLK_HZ;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SHOW = 2'd2
  } share_state_t;

  // Active-low digit anode enables used by display_four_digits
  localparam logic [3:0] DIGIT_EN_NONE = 4'b1111;
  localparam logic [3:0] DIGIT_EN_0    = 4'b1110;
  localparam logic [3:0] DIGIT_EN_1    = 4'b1101;
  localparam logic [3:0] DIGIT_EN_2    = 4'b1011;
  localparam logic [3:0] DIGIT_EN_3    = 4'b0111;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or above ptr (wrapping),
// skipping any requester set in exclude.
module rr_arbiter #(
  parameter int unsigned N     = 3,
  parameter int unsigned PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  input  logic [N-1:0]     exclude,
  output logic [N-1:0]     pick,
  output logic             pick_valid
);

  logic [N-1:0] masked;
  logic [N-1:0] rot;
  logic [N-1:0] rot_pick;
  logic         found;

  // Rotate so ptr lands at bit 0, take the lowest set bit, rotate back
  always_comb begin
    masked   = req & ~exclude;
    rot      = N'({masked, masked} >> ptr);
    rot_pick = '0;
    found    = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (rot[i] && !found) begin
        rot_pick[i] = 1'b1;
        found       = 1'b1;
      end
    end
    pick       = N'(({rot_pick, rot_pick} << ptr) >> N);
    pick_valid = |masked;
  end

endmodule

// File: rtl/display_share_ctrl.sv
// Time-shares the four-digit display between requesters with a minimum hold
// per grant and round-robin rotation at the end of each hold.
module display_share_ctrl
  import display_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 3,
  parameter int unsigned VALUE_W     = 16,
  parameter int unsigned HOLD_CYCLES = display_pkg::HOLD_CYCLES
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*VALUE_W-1:0] req_value,
  output logic                       start_signal,
  output logic [VALUE_W-1:0]         input_value,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       busy
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  share_state_t       state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [VALUE_W-1:0] value_q, value_d;
  logic               start_q, start_d;
  logic               busy_q, busy_d;

  logic [NUM_REQ-1:0] excl;
  logic [NUM_REQ-1:0] pick;
  logic               pick_valid;
  logic [PTR_W-1:0]   pick_idx;
  logic [PTR_W-1:0]   next_ptr;
  logic [VALUE_W-1:0] pick_val;
  logic [VALUE_W-1:0] owner_val;
  logic               owner_req;

  // Only the end-of-hold decision excludes the current owner
  assign excl = (state_q == SHOW) ? grant_q : '0;

  rr_arbiter #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .req        (req),
    .ptr        (ptr_q),
    .exclude    (excl),
    .pick       (pick),
    .pick_valid (pick_valid)
  );

  // One-hot decode of winner and current owner into index and values
  always_comb begin
    pick_idx  = '0;
    pick_val  = '0;
    owner_val = '0;
    owner_req = 1'b0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (pick[i]) begin
        pick_idx = PTR_W'(i);
        pick_val = req_value[i*VALUE_W +: VALUE_W];
      end
      if (grant_q[i]) begin
        owner_val = req_value[i*VALUE_W +: VALUE_W];
        owner_req = req[i];
      end
    end
    next_ptr = (pick_idx == PTR_W'(NUM_REQ - 1)) ? '0 : pick_idx + PTR_W'(1);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    value_d = value_q;
    start_d = 1'b0;
    busy_d  = busy_q;

    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = LOAD;
          start_d = 1'b1;
          grant_d = pick;
          busy_d  = 1'b1;
          value_d = pick_val;
          ptr_d   = next_ptr;
        end
      end
      LOAD: begin
        cnt_d   = HOLD_LOAD;
        state_d = SHOW;
      end
      SHOW: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (owner_req) value_d = owner_val;
        end else if (pick_valid) begin
          state_d = LOAD;
          start_d = 1'b1;
          grant_d = pick;
          value_d = pick_val;
          ptr_d   = next_ptr;
        end else if (owner_req) begin
          cnt_d   = HOLD_LOAD;
          value_d = owner_val;
        end else begin
          state_d = IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
      value_q <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      value_q <= value_d;
      start_q <= start_d;
      busy_q  <= busy_d;
    end
  end

  assign start_signal = start_q;
  assign input_value  = value_q;
  assign grant        = grant_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_display_share_ctrl.sv
// Bench for display_share_ctrl: directed scenarios plus random traffic, all
// compared each cycle against a grant/age reference model.
module tb_display_share_ctrl;

  localparam int N    = 3;
  localparam int VW   = 16;
  localparam int HOLD = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req;
  logic [N*VW-1:0]   req_value;
  logic              start_signal;
  logic [VW-1:0]     input_value;
  logic [N-1:0]      grant;
  logic              busy;

  always #5 clk = ~clk;

  display_share_ctrl #(
    .NUM_REQ     (N),
    .VALUE_W     (VW),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .req_value    (req_value),
    .start_signal (start_signal),
    .input_value  (input_value),
    .grant        (grant),
    .busy         (busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: owner index (-1 = none), age = cycles since the LOAD cycle
  int          m_owner;
  int          m_age;
  int          m_next;
  logic        m_start;
  logic        m_busy;
  logic [N-1:0] m_grant;
  logic [VW-1:0] m_value;

  function automatic int rr_pick(input logic [N-1:0] r, input int start, input int excl);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (start + k) % N;
      if (r[i] && i != excl) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_age   = 0;
    m_next  = 0;
    m_start = 1'b0;
    m_busy  = 1'b0;
    m_grant = '0;
    m_value = '0;
  endtask

  task automatic model_grant(input int w, input logic [N*VW-1:0] v);
    m_owner = w;
    m_age   = 0;
    m_start = 1'b1;
    m_busy  = 1'b1;
    m_grant = N'(1 << w);
    m_value = v[w*VW +: VW];
    m_next  = (w + 1) % N;
  endtask

  task automatic model_step(input logic [N-1:0] r, input logic [N*VW-1:0] v);
    int w;
    m_start = 1'b0;
    if (m_owner < 0) begin
      w = rr_pick(r, m_next, -1);
      if (w >= 0) model_grant(w, v);
    end else if (m_age == 0) begin
      m_age = 1;
    end else if (m_age < HOLD) begin
      m_age++;
      if (r[m_owner]) m_value = v[m_owner*VW +: VW];
    end else begin
      w = rr_pick(r, m_next, m_owner);
      if (w >= 0) begin
        model_grant(w, v);
      end else if (r[m_owner]) begin
        m_age   = 1;
        m_value = v[m_owner*VW +: VW];
      end else begin
        m_owner = -1;
        m_grant = '0;
        m_busy  = 1'b0;
      end
    end
  endtask

  task automatic compare_outputs();
    check("start", 32'(start_signal), 32'(m_start));
    check("grant", 32'(grant), 32'(m_grant));
    check("busy",  32'(busy),  32'(m_busy));
    check("value", 32'(input_value), 32'(m_value));
  endtask

  task automatic cycle(input logic [N-1:0] r, input logic [N*VW-1:0] v);
    @(negedge clk);
    compare_outputs();
    req       = r;
    req_value = v;
    model_step(r, v);
  endtask

  // Assert reset mid-cycle, check outputs clear before any clock edge
  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst_async_start", 32'(start_signal), 32'd0);
    check("rst_async_grant", 32'(grant), 32'd0);
    check("rst_async_busy",  32'(busy),  32'd0);
    check("rst_async_value", 32'(input_value), 32'd0);
    model_reset();
    @(negedge clk);
    compare_outputs();
    reset = 1'b0;
    model_step(req, req_value);
  endtask

  logic [N*VW-1:0] vals;
  logic [N-1:0]    rq;
  logic [N*VW-1:0] rv;

  initial begin
    reset     = 1'b1;
    req       = '0;
    req_value = '0;
    model_reset();
    repeat (3) @(negedge clk);
    compare_outputs();
    reset = 1'b0;
    model_step(req, req_value);

    // Idle after reset: no pulse, everything zero
    vals = {16'h5678, 16'h1234, 16'hABCD};
    for (int c = 0; c < 20; c++) cycle(3'b000, vals);

    // Single requester, then drop
    for (int c = 0; c < 5; c++)  cycle(3'b001, vals);
    for (int c = 0; c < 15; c++) cycle(3'b000, vals);

    // All three requesting: strict rotation with 9-cycle spacing
    for (int c = 0; c < 40; c++) cycle(3'b111, vals);
    for (int c = 0; c < 15; c++) cycle(3'b000, vals);

    // Owner alone with a live value change mid-hold, then hold renewal
    for (int c = 0; c < 5; c++)  cycle(3'b001, vals);
    vals[15:0] = 16'h1234;
    for (int c = 0; c < 20; c++) cycle(3'b001, vals);
    for (int c = 0; c < 12; c++) cycle(3'b000, vals);

    // Owner 1 showing, requester 0 joins mid-hold
    vals = {16'h5678, 16'h1234, 16'hABCD};
    for (int c = 0; c < 4; c++)  cycle(3'b010, vals);
    for (int c = 0; c < 20; c++) cycle(3'b011, vals);

    // Reset during SHOW, then pointer restarts at 0
    for (int c = 0; c < 4; c++) cycle(3'b010, vals);
    do_reset();
    for (int c = 0; c < 6; c++) cycle(3'b110, vals);
    for (int c = 0; c < 15; c++) cycle(3'b000, vals);

    // Random traffic with live value changes and occasional resets
    rq = '0;
    rv = vals;
    for (int c = 0; c < 1500; c++) begin
      int s;
      if ($urandom_range(0, 7) == 0) rq = N'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) begin
        s = int'($urandom_range(0, N - 1));
        rv[s*VW +: VW] = VW'($urandom);
      end
      req       = req;
      if ($urandom_range(0, 299) == 0) do_reset();
      else cycle(rq, rv);
    end
    cycle('0, rv);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
